// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types for the object (sprite) pixel path.
//   sprite_data_t : per-pixel sprite query result from the sprite chain,
//                   {dy[2:0], tile[7:0], attrs[3:0]}.
//   obj_pixel_t   : one object pixel {color[1:0], pal, bg_prio}.
//   obj_row_t     : eight object pixels, index 0 = leftmost / shifter head.
//   fetch_state_t : tile-row fetch FSM states.
//   decode_row()  : turns two bitplane bytes plus attributes into a row.
package ppu_pkg;

  localparam int ATTR_PRIO  = 3;
  localparam int ATTR_YFLIP = 2;
  localparam int ATTR_XFLIP = 1;
  localparam int ATTR_PAL   = 0;

  typedef struct packed {
    logic [2:0] dy;
    logic [7:0] tile;
    logic [3:0] attrs;
  } sprite_data_t;

  typedef struct packed {
    logic [1:0] color;
    logic       pal;
    logic       bg_prio;
  } obj_pixel_t;

  typedef obj_pixel_t [7:0] obj_row_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_MERGE
  } fetch_state_t;

  // Bit 7 of each plane is the leftmost pixel unless the sprite is
  // mirrored horizontally, in which case bit 0 is leftmost.
  function automatic obj_row_t decode_row(input logic [7:0] lo,
                                          input logic [7:0] hi,
                                          input logic [3:0] attrs);
    obj_row_t   row;
    logic [2:0] b;
    row = '0;
    for (int i = 0; i < 8; i++) begin
      b = attrs[ATTR_XFLIP] ? 3'(i) : 3'(7 - i);
      row[i].color   = {hi[b], lo[b]};
      row[i].pal     = attrs[ATTR_PAL];
      row[i].bg_prio = attrs[ATTR_PRIO];
    end
    return row;
  endfunction

endpackage

// File: rtl/sprite_pixel_fifo.sv
// sprite_pixel_fifo: 8-slot object pixel shifter.
//   clk          : clock
//   rst          : asynchronous active-high reset, all slots transparent
//   i_clear      : synchronous clear of all slots (highest priority)
//   i_merge_en   : merge i_merge_row into the slots this cycle
//   i_merge_row  : candidate pixels, index 0 = slot 0
//   i_advance    : shift slot k+1 into slot k, slot 7 refilled transparent
//   o_head       : current contents of slot 0
module sprite_pixel_fifo
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_merge_en,
  input  obj_row_t   i_merge_row,
  input  logic       i_advance,
  output obj_pixel_t o_head
);

  obj_row_t r_slots;

  // A slot already holding an opaque pixel belongs to an earlier, higher
  // priority sprite, so only transparent slots accept new opaque pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slots <= '0;
    end else if (i_clear) begin
      r_slots <= '0;
    end else if (i_merge_en) begin
      for (int i = 0; i < 8; i++) begin
        if ((r_slots[i].color == 2'b00) && (i_merge_row[i].color != 2'b00))
          r_slots[i] <= i_merge_row[i];
      end
    end else if (i_advance) begin
      r_slots <= {obj_pixel_t'(4'b0000), r_slots[7:1]};
    end
  end

  assign o_head = r_slots[0];

endmodule

// File: rtl/sprite_fetcher.sv
// sprite_fetcher: fetches the tile row of each sprite reported by the
// sprite chain and merges it into the object pixel shifter.
//   clk, rst     : clock, asynchronous active-high reset
//   line_start   : start of scan line, clears shifter and aborts any fetch
//   active       : pixel transfer in progress, gates chain queries
//   spr_data     : sprite_data_t from the chain, spr_valid qualifies it
//   query        : query strobe to the chain
//   vram_addr    : tile-row byte address, vram_rd read strobe
//   vram_d_in    : VRAM read data, one cycle after vram_rd
//   pix_advance  : pixel pipeline consumes one object pixel
//   stall        : pixel pipeline must hold lx
//   obj_pix      : obj_pixel_t at the shifter head
//   stall_cycles : stalled-cycle counter, present only when the macro
//                  SPRITE_FETCH_PERF_EN is defined
module sprite_fetcher
  import ppu_pkg::*;
#(
  parameter int                     VRAM_ADDR_W   = 13,
  parameter logic [VRAM_ADDR_W-1:0] OBJ_TILE_BASE = 13'h0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   line_start,
  input  logic                   active,
  input  logic [14:0]            spr_data,
  input  logic                   spr_valid,
  output logic                   query,
  output logic [VRAM_ADDR_W-1:0] vram_addr,
  output logic                   vram_rd,
  input  logic [7:0]             vram_d_in,
  input  logic                   pix_advance,
  output logic                   stall,
  output logic [3:0]             obj_pix
`ifdef SPRITE_FETCH_PERF_EN
  ,
  output logic [15:0]            stall_cycles
`endif
);

  fetch_state_t r_state;
  fetch_state_t w_next;
  sprite_data_t r_spr;
  logic [7:0]   r_lo;
  logic         w_start;
  logic         w_plane;
  logic         w_merge;
  logic         w_advance;
  obj_row_t     w_row;
  obj_pixel_t   w_head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (line_start) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_start) w_next = ST_LO;
        ST_LO:    w_next = ST_HI;
        ST_HI:    w_next = ST_MERGE;
        ST_MERGE: w_next = ST_IDLE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // The stall must be raised in the same cycle a sprite is accepted so that
  // lx does not move on before the fetch has started.
  always_comb begin
    query     = active & (r_state == ST_IDLE) & ~line_start;
    w_start   = query & spr_valid;
    stall     = (r_state != ST_IDLE) | w_start;
    vram_rd   = (r_state == ST_LO) | (r_state == ST_HI);
    w_plane   = (r_state == ST_HI);
    w_merge   = (r_state == ST_MERGE) & ~line_start;
    w_advance = pix_advance & ~stall;
    vram_addr = '0;
    if (vram_rd)
      vram_addr = OBJ_TILE_BASE + VRAM_ADDR_W'({r_spr.tile, r_spr.dy, w_plane});
  end

  // The low plane arrives while in HI; the high plane is used straight off
  // the bus in MERGE, so it never needs a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spr <= '0;
      r_lo  <= '0;
    end else begin
      if (w_start)            r_spr <= sprite_data_t'(spr_data);
      if (r_state == ST_HI)   r_lo  <= vram_d_in;
    end
  end

  assign w_row = decode_row(r_lo, vram_d_in, r_spr.attrs);

  sprite_pixel_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (line_start),
    .i_merge_en  (w_merge),
    .i_merge_row (w_row),
    .i_advance   (w_advance),
    .o_head      (w_head)
  );

  assign obj_pix = w_head;

`ifdef SPRITE_FETCH_PERF_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stall_cycles <= '0;
    else if (line_start)
      r_stall_cycles <= '0;
    else if (stall && (r_stall_cycles != 16'hFFFF))
      r_stall_cycles <= r_stall_cycles + 16'd1;
  end

  assign stall_cycles = r_stall_cycles;
`endif

`ifndef SYNTHESIS
  // An advance during a stall is dropped; the pipeline should never ask.
  always @(posedge clk) begin
    if (!rst) assert (!(pix_advance && stall));
  end
`endif

endmodule

// File: tb/tb_sprite_fetcher.sv
// tb_sprite_fetcher: self-checking bench for sprite_fetcher. Fixed vector
// table for the documented scenarios, hand sequences for reset and the
// optional stall counter, then randomized traffic against a reference model.
module tb_sprite_fetcher;
  import ppu_pkg::*;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          line_start;
  logic          active;
  logic [14:0]   spr_data;
  logic          spr_valid;
  logic          query;
  logic [AW-1:0] vram_addr;
  logic          vram_rd;
  logic [7:0]    vram_d_in;
  logic          pix_advance;
  logic          stall;
  logic [3:0]    obj_pix;
`ifdef SPRITE_FETCH_PERF_EN
  logic [15:0]   stall_cycles;
`endif

  always #5 clk = ~clk;

  sprite_fetcher #(.VRAM_ADDR_W(AW), .OBJ_TILE_BASE(13'h0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .line_start   (line_start),
    .active       (active),
    .spr_data     (spr_data),
    .spr_valid    (spr_valid),
    .query        (query),
    .vram_addr    (vram_addr),
    .vram_rd      (vram_rd),
    .vram_d_in    (vram_d_in),
    .pix_advance  (pix_advance),
    .stall        (stall),
    .obj_pix      (obj_pix)
`ifdef SPRITE_FETCH_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  logic [7:0] mem [0:8191];

  int errors = 0;
  int checks = 0;

  // Reference model: shifter contents, fetch progress (cycles since accept),
  // the row the accepted sprite will contribute, and the stall count.
  logic [3:0] mSlots [8];
  logic [3:0] mRow   [8];
  int         mPhase;
  int         mAddr;
  int         mStallCnt;

  logic        eQuery, eStall, eRd;
  logic [12:0] eAddr;
  logic [3:0]  ePix;
  int          eCnt;

  logic        sQuery, sStall, sRd;
  logic [12:0] sAddr;
  logic [3:0]  sPix;
  logic        prevRd;
  logic [12:0] prevAddr;

  typedef struct {
    logic        ls, act, valid, adv;
    logic [14:0] spr;
    logic        eq, est, erd;
    logic [12:0] eaddr;
    logic [3:0]  epix;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) begin
      mSlots[i] = 4'h0;
      mRow[i]   = 4'h0;
    end
    mPhase    = 0;
    mAddr     = 0;
    mStallCnt = 0;
  endtask

  task automatic modelStep(input logic ls, input logic valid, input logic adv,
                           input logic [14:0] spr);
    int lo, hi, b, color, tile, dy;
    logic [3:0] attrs;
    if (ls) begin
      for (int i = 0; i < 8; i++) mSlots[i] = 4'h0;
      mPhase = 0;
    end else begin
      if (mPhase == 3) begin
        for (int i = 0; i < 8; i++)
          if (mSlots[i][3:2] == 2'b00 && mRow[i][3:2] != 2'b00) mSlots[i] = mRow[i];
      end
      if (adv) begin
        for (int i = 0; i < 7; i++) mSlots[i] = mSlots[i+1];
        mSlots[7] = 4'h0;
      end
      if (mPhase == 0) begin
        if (eQuery && valid) begin
          dy    = int'(spr[14:12]);
          tile  = int'(spr[11:4]);
          attrs = spr[3:0];
          mAddr = tile * 16 + dy * 2;
          lo    = int'(mem[mAddr]);
          hi    = int'(mem[mAddr + 1]);
          for (int i = 0; i < 8; i++) begin
            b     = attrs[1] ? i : 7 - i;
            color = ((hi >> b) & 1) * 2 + ((lo >> b) & 1);
            mRow[i] = 4'(color * 4 + int'(attrs[0]) * 2 + int'(attrs[3]));
          end
          mPhase = 1;
        end
      end else begin
        mPhase = (mPhase == 3) ? 0 : mPhase + 1;
      end
    end
    if (ls) mStallCnt = 0;
    else if (eStall && mStallCnt < 65535) mStallCnt++;
  endtask

  // Drives one cycle at the falling edge, samples #1 later, advances model.
  task automatic applyStimulus(input logic ls, input logic act, input logic valid,
                               input logic adv, input logic [14:0] spr);
    logic advEff;
    @(negedge clk);
    eQuery = act && (mPhase == 0) && !ls;
    eStall = (mPhase != 0) || (eQuery && valid);
    eRd    = (mPhase == 1) || (mPhase == 2);
    eAddr  = eRd ? 13'((mAddr + ((mPhase == 2) ? 1 : 0)) & 8191) : 13'd0;
    ePix   = mSlots[0];
    eCnt   = mStallCnt;
    advEff = adv && !eStall;
    line_start  = ls;
    active      = act;
    spr_valid   = valid;
    pix_advance = advEff;
    spr_data    = spr;
    vram_d_in   = prevRd ? mem[prevAddr] : 8'($urandom);
    #1;
    sQuery   = query;
    sStall   = stall;
    sRd      = vram_rd;
    sAddr    = vram_addr;
    sPix     = obj_pix;
    prevRd   = vram_rd;
    prevAddr = vram_addr;
    modelStep(ls, valid, advEff, spr);
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " query"}, 32'(sQuery), 32'(eQuery));
    checkOutput({tag, " stall"}, 32'(sStall), 32'(eStall));
    checkOutput({tag, " vram_rd"}, 32'(sRd), 32'(eRd));
    checkOutput({tag, " vram_addr"}, 32'(sAddr), 32'(eAddr));
    checkOutput({tag, " obj_pix"}, 32'(sPix), 32'(ePix));
`ifdef SPRITE_FETCH_PERF_EN
    checkOutput({tag, " stall_cycles"}, 32'(stall_cycles), 32'(eCnt));
`endif
  endtask

  task automatic addRow(input logic ls, input logic act, input logic valid,
                        input logic adv, input logic [14:0] spr, input logic eq,
                        input logic est, input logic erd, input logic [12:0] eaddr,
                        input logic [3:0] epix);
    vec_t v;
    v.ls = ls; v.act = act; v.valid = valid; v.adv = adv; v.spr = spr;
    v.eq = eq; v.est = est; v.erd = erd; v.eaddr = eaddr; v.epix = epix;
    vecs.push_back(v);
  endtask

  initial begin
    logic [14:0] s1, s1x, sa, sb;
    logic [3:0]  patA [9];
    logic [3:0]  patB [9];
    logic [3:0]  patC [9];

    s1  = {3'd3, 8'h12, 4'b0000};
    s1x = {3'd3, 8'h12, 4'b0010};
    sa  = {3'd0, 8'h20, 4'b0000};
    sb  = {3'd5, 8'h21, 4'b0001};
    patA = '{4'hC, 4'hC, 4'h4, 4'h4, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0};
    patB = '{4'h0, 4'h0, 4'h8, 4'h8, 4'h4, 4'h4, 4'hC, 4'hC, 4'h0};
    patC = '{4'h4, 4'h4, 4'h4, 4'h4, 4'hE, 4'hE, 4'hE, 4'hE, 4'h0};

    for (int a = 0; a < 8192; a++) mem[a] = 8'($urandom);
    mem[13'h126] = 8'hF0; mem[13'h127] = 8'hCC;
    mem[13'h200] = 8'hF0; mem[13'h201] = 8'h00;
    mem[13'h21A] = 8'hFF; mem[13'h21B] = 8'hFF;

    // single sprite, then eight advances
    addRow(0, 1, 1, 0, s1, 1, 1, 0, 13'h000, 4'h0);
    addRow(0, 1, 0, 0, 0,  0, 1, 1, 13'h126, 4'h0);
    addRow(0, 1, 0, 0, 0,  0, 1, 1, 13'h127, 4'h0);
    addRow(0, 1, 0, 0, 0,  0, 1, 0, 13'h000, 4'h0);
    for (int i = 0; i < 9; i++) addRow(0, 1, 0, 1, 0, 1, 0, 0, 13'h000, patA[i]);
    // mirrored sprite
    addRow(1, 1, 0, 0, 0,   0, 0, 0, 13'h000, 4'h0);
    addRow(0, 1, 1, 0, s1x, 1, 1, 0, 13'h000, 4'h0);
    addRow(0, 1, 0, 0, 0,   0, 1, 1, 13'h126, 4'h0);
    addRow(0, 1, 0, 0, 0,   0, 1, 1, 13'h127, 4'h0);
    addRow(0, 1, 0, 0, 0,   0, 1, 0, 13'h000, 4'h0);
    for (int i = 0; i < 9; i++) addRow(0, 1, 0, 1, 0, 1, 0, 0, 13'h000, patB[i]);
    // two sprites at the same lx, first one wins overlapping slots
    addRow(1, 1, 0, 0, 0,  0, 0, 0, 13'h000, 4'h0);
    addRow(0, 1, 1, 0, sa, 1, 1, 0, 13'h000, 4'h0);
    addRow(0, 1, 1, 0, sa, 0, 1, 1, 13'h200, 4'h0);
    addRow(0, 1, 1, 0, sa, 0, 1, 1, 13'h201, 4'h0);
    addRow(0, 1, 1, 0, sa, 0, 1, 0, 13'h000, 4'h0);
    addRow(0, 1, 1, 0, sb, 1, 1, 0, 13'h000, 4'h4);
    addRow(0, 1, 1, 0, sb, 0, 1, 1, 13'h21A, 4'h4);
    addRow(0, 1, 1, 0, sb, 0, 1, 1, 13'h21B, 4'h4);
    addRow(0, 1, 1, 0, sb, 0, 1, 0, 13'h000, 4'h4);
    for (int i = 0; i < 9; i++) addRow(0, 1, 0, 1, 0, 1, 0, 0, 13'h000, patC[i]);
    // line_start while in HI aborts the fetch
    addRow(1, 1, 0, 0, 0,  0, 0, 0, 13'h000, 4'h0);
    addRow(0, 1, 1, 0, s1, 1, 1, 0, 13'h000, 4'h0);
    addRow(0, 1, 0, 0, 0,  0, 1, 1, 13'h126, 4'h0);
    addRow(1, 1, 0, 0, 0,  0, 1, 1, 13'h127, 4'h0);
    addRow(0, 1, 0, 0, 0,  1, 0, 0, 13'h000, 4'h0);
    addRow(0, 1, 0, 1, 0,  1, 0, 0, 13'h000, 4'h0);
    addRow(0, 1, 0, 0, 0,  1, 0, 0, 13'h000, 4'h0);

    rst = 1'b1; line_start = 0; active = 0; spr_valid = 0; spr_data = '0;
    pix_advance = 0; vram_d_in = '0; prevRd = 0; prevAddr = '0;
    modelReset();

    @(negedge clk);
    #1;
    checkOutput("reset query", 32'(query), 32'd0);
    checkOutput("reset stall", 32'(stall), 32'd0);
    checkOutput("reset vram_rd", 32'(vram_rd), 32'd0);
    checkOutput("reset vram_addr", 32'(vram_addr), 32'd0);
    checkOutput("reset obj_pix", 32'(obj_pix), 32'd0);
`ifdef SPRITE_FETCH_PERF_EN
    checkOutput("reset stall_cycles", 32'(stall_cycles), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ls, vecs[i].act, vecs[i].valid, vecs[i].adv, vecs[i].spr);
      checkOutput($sformatf("row%0d query", i), 32'(sQuery), 32'(vecs[i].eq));
      checkOutput($sformatf("row%0d stall", i), 32'(sStall), 32'(vecs[i].est));
      checkOutput($sformatf("row%0d vram_rd", i), 32'(sRd), 32'(vecs[i].erd));
      checkOutput($sformatf("row%0d vram_addr", i), 32'(sAddr), 32'(vecs[i].eaddr));
      checkOutput($sformatf("row%0d obj_pix", i), 32'(sPix), 32'(vecs[i].epix));
    end

    // reset asserted in the middle of a fetch with a populated shifter
    applyStimulus(1, 1, 0, 0, 0);   checkModel("rstseq clr");
    applyStimulus(0, 1, 1, 0, s1);  checkModel("rstseq acc1");
    repeat (3) begin
      applyStimulus(0, 1, 0, 0, 0); checkModel("rstseq fetch1");
    end
    applyStimulus(0, 1, 1, 0, s1x); checkModel("rstseq acc2");
    applyStimulus(0, 1, 0, 0, 0);   checkModel("rstseq lo2");
    @(negedge clk);
    line_start = 0; active = 0; spr_valid = 0; pix_advance = 0; rst = 1'b1;
    #1;
    checkOutput("midrst query", 32'(query), 32'd0);
    checkOutput("midrst stall", 32'(stall), 32'd0);
    checkOutput("midrst vram_rd", 32'(vram_rd), 32'd0);
    checkOutput("midrst vram_addr", 32'(vram_addr), 32'd0);
    checkOutput("midrst obj_pix", 32'(obj_pix), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    prevRd = 0;
    applyStimulus(0, 1, 0, 0, 0);   checkModel("rstseq after");

`ifdef SPRITE_FETCH_PERF_EN
    applyStimulus(1, 1, 0, 0, 0);   checkModel("perf clr");
    for (int k = 0; k < 12; k++) begin
      applyStimulus(0, 1, 1, 0, (k < 4) ? sa : ((k < 8) ? sb : s1));
      checkModel("perf fetch");
    end
    applyStimulus(0, 1, 0, 0, 0);   checkModel("perf idle");
    checkOutput("perf three sprites", 32'(stall_cycles), 32'd12);
    applyStimulus(1, 1, 0, 0, 0);   checkModel("perf ls");
    applyStimulus(0, 1, 0, 0, 0);   checkModel("perf after ls");
    checkOutput("perf cleared", 32'(stall_cycles), 32'd0);
`endif

    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
                    $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                    15'($urandom));
      checkModel($sformatf("rand%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_fetcher.md
Name: sprite_fetcher

Overview:
- Sits directly downstream of the sprite chain in the PPU pixel path.
- Consumes the per-pixel sprite query result (sprite_data_t plus valid) for the current lx.
- Fetches the two bitplane bytes of that sprite's tile row from VRAM and merges them into an 8-slot object pixel shifter.
- Presents one object pixel per advanced screen pixel to the BG/OBJ mixer, and stalls the pixel pipeline while fetches are pending.

Parameters:
- VRAM_ADDR_W, 13, VRAM byte address width.
- OBJ_TILE_BASE, 13'h0000, base address of object tile data.

Ports:
- clk  in  1  clock.
- rst  in  1  reset (see interface rule below).
- line_start  in  1  one-cycle pulse at start of each scan line; clears shifter and aborts FSM.
- active  in  1  pixel transfer phase in progress; query enable gate.
- spr_data  in  15  sprite_data_t from chain: dy[2:0], tile[7:0], attrs[3:0] = {bg_prio, yflip, xflip, pal}.
- spr_valid  in  1  chain has a matching sprite for current lx.
- query  out  1  drives chain query input; = active & (state==IDLE) & ~line_start.
- vram_addr  out  VRAM_ADDR_W  tile-row byte address.
- vram_rd  out  1  read strobe.
- vram_d_in  in  8  read data, valid exactly 1 cycle after vram_rd.
- pix_advance  in  1  pixel pipeline shifts one pixel out this cycle.
- stall  out  1  pixel pipeline must not advance lx.
- obj_pix  out  4  obj_pixel_t {color[1:0], pal, bg_prio} of shifter slot 0.

Interface rule: one clock, clk; reset rst is asynchronous, active-high.

Behaviour:
- Reset: state=IDLE, all shifter slots transparent (color 0, pal 0, prio 0). Outputs: vram_rd=0, vram_addr=0, stall=0, obj_pix=0, query=0.
- FSM states: IDLE, LO, HI, MERGE.
  - IDLE: if query & spr_valid, latch spr_data and go to LO.
  - LO: vram_rd=1, addr plane 0; go to HI.
  - HI: capture vram_d_in as lo byte; vram_rd=1, addr plane 1; go to MERGE.
  - MERGE: capture vram_d_in as hi byte; merge into shifter; go to IDLE.
- Address: OBJ_TILE_BASE + {tile, dy, plane} (tile*16 + dy*2 + plane), truncated to VRAM_ADDR_W. dy already has yflip applied upstream.
- stall = (state!=IDLE) | (query & spr_valid), combinational.
  - Sprite valid in IDLE at cycle N: stall is high N..N+3, merge happens at N+3, query is re-issued at N+4.
  - Several sprites at the same x therefore fetch back-to-back, 4 cycles each. Chain order gives OAM priority.
- Pixel order: pixel i (i=0 leftmost) color = {hi[7-i], lo[7-i]}. With xflip set, use bit i instead.
- Merge rule: for each slot i, replace only if the existing slot color==0; earlier (higher-priority) sprites win. Transparent new pixels never overwrite.
- pix_advance: shift slot k+1 into slot k; slot 7 is filled transparent. Only honoured when stall=0. If pix_advance arrives while stall=1, it is ignored and flagged by an assertion.
- line_start: synchronous clear of shifter; FSM forced to IDLE, even mid-fetch. Any in-flight VRAM data is discarded. Has priority over merge and pix_advance in the same cycle.
- active=0: query=0, no new fetch starts. A fetch already in progress completes.
- Sprites with x<8 merge as usual. The pixel pipeline discards the first 8 shifted pixels; this block does no clipping.
- rst asserted mid-fetch: immediate return to reset values.

Optional Feature:
- Macro: SPRITE_FETCH_PERF_EN.
- Defined: adds output port stall_cycles[15:0], counting cycles with stall=1. Cleared at line_start, saturates at 16'hFFFF, reset to 0.
- Undefined: port and counter absent. All other behaviour identical.

Decomposition:
- Package ppu_pkg: sprite_data_t, obj_pixel_t, fetch FSM enum, attr bit index constants (ATTR_PRIO=3, ATTR_YFLIP=2, ATTR_XFLIP=1, ATTR_PAL=0).
- Sub-module sprite_pixel_fifo: 8-slot shifter with merge and advance ports. The FSM and address generation stay in sprite_fetcher.

Test Plan:
- Single sprite: tile=8'h12, dy=3, attrs=0, VRAM[0x0126]=8'hF0, VRAM[0x0127]=8'hCC → addrs 0x126 then 0x127; stall 4 cycles; slots 0..7 colors = 3,3,1,1,2,2,0,0.
- Same data with xflip (attrs=4'b0010) → slots 0..7 colors = 0,0,2,2,1,1,3,3.
- Two sprites at same lx: first lo=8'hF0/hi=0, second lo=8'hFF/hi=8'hFF with pal=1 → slots 0..3 color 1 pal 0; slots 4..7 color 3 pal 1; total stall 8 cycles.
- Shift: after single-sprite merge, 8 pix_advance pulses → obj_pix colors emitted 3,3,1,1,2,2,0,0, then color 0.
- line_start asserted in state HI → next cycle state IDLE, shifter all transparent, no merge, query re-asserted when active.
- With SPRITE_FETCH_PERF_EN: three sprites fetched on one line → stall_cycles=12; after line_start → 0.
